// File: rtl/exc_controller.sv
// Exception requester for the datapath's Exc/EStatus/ExcAck handshake.
// Latches external interrupt pulses into sticky pending bits and arbitrates
// them against the synchronous invalid-opcode exception. A request is held
// until the datapath acknowledges it. Nested exceptions are then blocked
// until ERET.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no request outstanding; inv_opcode raises Exc combinationally
//   RAISE    | Exc held with a registered cause, waiting for ExcAck
//   HANDLER  | handler running; requests blocked until ERet
module exc_controller #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] ext_irq,
  input  logic [NSRC-1:0] irq_en,
  input  logic            inv_opcode,
  input  logic            ExcAck,
  input  logic            ERet,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic [NSRC-1:0] pending,
  output logic            in_handler,
  output logic            double_fault
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAISE   = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  localparam logic [3:0] CAUSE_INV = 4'b0010;
  localparam logic [3:0] CAUSE_EXT = 4'b1000;
  localparam int         SW        = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_e          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] clr_mask;
  logic [3:0]      cause_q, cause_d;
  logic [SW-1:0]   taken_src_q, taken_src_d;
  logic            double_fault_q, double_fault_d;

  logic [NSRC-1:0] ready_irq;
  logic            irq_hit;
  logic [SW-1:0]   irq_idx;

  // State register; reset aborts any outstanding request or handler at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      cause_q        <= 4'b0000;
      taken_src_q    <= '0;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      cause_q        <= cause_d;
      taken_src_q    <= taken_src_d;
      double_fault_q <= double_fault_d;
    end
  end

  // Lowest-index enabled pending source wins arbitration
  always_comb begin
    ready_irq = pending_q & irq_en;
    irq_hit   = 1'b0;
    irq_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (ready_irq[i]) begin
        irq_hit = 1'b1;
        irq_idx = SW'(i);
      end
    end
  end

  // Next-state, captured cause and sticky pending/double-fault tracking
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    taken_src_d    = taken_src_q;
    double_fault_d = double_fault_q;
    clr_mask       = '0;

    case (state_q)
      ST_IDLE: begin
        if (inv_opcode) begin
          cause_d = CAUSE_INV;
          state_d = ExcAck ? ST_HANDLER : ST_RAISE;
        end else if (irq_hit) begin
          cause_d     = CAUSE_EXT | 4'(irq_idx);
          taken_src_d = irq_idx;
          state_d     = ST_RAISE;
        end
      end
      ST_RAISE: begin
        if (ExcAck) begin
          // An ack taken while inv_opcode overrides the displayed cause
          // acknowledges the sync exception, so the interrupt stays pending.
          if (cause_q[3] && !inv_opcode) begin
            clr_mask = NSRC'(1) << taken_src_q;
          end
          state_d = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (inv_opcode) begin
          double_fault_d = 1'b1;
        end
        if (ERet) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new pulse on the clearing edge keeps the bit pending
    pending_d = (pending_q & ~clr_mask) | ext_irq;
  end

  // Request outputs; EStatus is forced to zero whenever Exc is low
  always_comb begin
    Exc     = 1'b0;
    EStatus = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (inv_opcode) begin
          Exc     = 1'b1;
          EStatus = CAUSE_INV;
        end
      end
      ST_RAISE: begin
        Exc     = 1'b1;
        EStatus = inv_opcode ? CAUSE_INV : cause_q;
      end
      default: begin
        Exc     = 1'b0;
        EStatus = 4'b0000;
      end
    endcase
  end

  assign pending      = pending_q;
  assign in_handler   = (state_q == ST_HANDLER);
  assign double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_controller.sv
// Bench for exc_controller: directed scenarios followed by random traffic.
// Each cycle the stimulus process pushes the reference model's expected
// outputs into a queue. A monitor pops and compares them at the falling edge.
module tb_exc_controller;

  localparam int NSRC = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NSRC-1:0] ext_irq = '0;
  logic [NSRC-1:0] irq_en = '0;
  logic            inv_opcode = 1'b0;
  logic            ExcAck = 1'b0;
  logic            ERet = 1'b0;
  logic            Exc;
  logic [3:0]      EStatus;
  logic [NSRC-1:0] pending;
  logic            in_handler;
  logic            double_fault;

  exc_controller #(.NSRC(NSRC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ext_irq      (ext_irq),
    .irq_en       (irq_en),
    .inv_opcode   (inv_opcode),
    .ExcAck       (ExcAck),
    .ERet         (ERet),
    .Exc          (Exc),
    .EStatus      (EStatus),
    .pending      (pending),
    .in_handler   (in_handler),
    .double_fault (double_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            exc;
    bit [3:0]      es;
    bit [NSRC-1:0] pend;
    bit            inh;
    bit            df;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: a request either is outstanding (with the source it
  // came from, -1 for the invalid opcode) or not; the handler is either
  // running or not.
  bit [NSRC-1:0] m_pend;
  bit            m_raising;
  int            m_src;
  bit            m_inh;
  bit            m_df;

  task automatic model_clear();
    m_pend    = '0;
    m_raising = 1'b0;
    m_src     = -1;
    m_inh     = 1'b0;
    m_df      = 1'b0;
  endtask

  task automatic model_step(input bit [NSRC-1:0] irq, input bit [NSRC-1:0] en,
                            input bit inv, input bit ack, input bit er);
    bit [NSRC-1:0] clr;
    int            pick;
    clr = '0;
    if (m_inh) begin
      if (inv) m_df = 1'b1;
      if (er) m_inh = 1'b0;
    end else if (m_raising) begin
      if (ack) begin
        if (m_src >= 0 && !inv) clr[m_src] = 1'b1;
        m_raising = 1'b0;
        m_inh     = 1'b1;
      end
    end else if (inv) begin
      if (ack) m_inh = 1'b1;
      else begin
        m_raising = 1'b1;
        m_src     = -1;
      end
    end else begin
      pick = -1;
      for (int i = 0; i < NSRC; i++) begin
        if (pick < 0 && m_pend[i] && en[i]) pick = i;
      end
      if (pick >= 0) begin
        m_raising = 1'b1;
        m_src     = pick;
      end
    end
    m_pend = (m_pend & ~clr) | irq;
  endtask

  task automatic cyc(input bit r, input bit [NSRC-1:0] irq, input bit [NSRC-1:0] en,
                     input bit inv, input bit ack, input bit er);
    exp_t e;
    reset      = r;
    ext_irq    = irq;
    irq_en     = en;
    inv_opcode = inv;
    ExcAck     = ack;
    ERet       = er;
    if (!r) model_clear();
    e.exc  = m_raising || (!m_inh && inv);
    if (!e.exc)                e.es = 4'd0;
    else if (inv || m_src < 0) e.es = 4'b0010;
    else                       e.es = 4'(8 + m_src);
    e.pend = m_pend;
    e.inh  = m_inh;
    e.df   = m_df;
    expq.push_back(e);
    @(posedge clk);
    if (r) model_step(irq, en, inv, ack, er);
    else   model_clear();
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("Exc",          int'(Exc),          int'(e.exc));
        chk("EStatus",      int'(EStatus),      int'(e.es));
        chk("pending",      int'(pending),      int'(e.pend));
        chk("in_handler",   int'(in_handler),   int'(e.inh));
        chk("double_fault", int'(double_fault), int'(e.df));
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1;

    // Reset with pulses present, then a single interrupt held unacked
    repeat (3) cyc(0, 4'b0101, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0100, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    repeat (3) cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 1);
    repeat (2) cyc(1, 4'b0000, 4'b1111, 0, 0, 0);

    // Two simultaneous sources: lower index first
    cyc(1, 4'b0110, 4'b1111, 0, 0, 0);
    repeat (2) cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 1);
    repeat (2) cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 1);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);

    // Invalid opcode acked immediately, then a double fault
    cyc(1, 4'b0000, 4'b1111, 1, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 1, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 1);
    repeat (2) cyc(1, 4'b0000, 4'b1111, 0, 0, 0);

    // Masked source stays pending until enabled
    cyc(1, 4'b0001, 4'b1110, 0, 0, 0);
    repeat (3) cyc(1, 4'b0000, 4'b1110, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 1);

    // Pulse on the ack edge keeps the bit; reset mid-handler
    cyc(1, 4'b0010, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0010, 4'b1111, 0, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(0, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);

    // Sync exception overriding a raised interrupt on its ack edge
    cyc(1, 4'b1000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 0);
    cyc(1, 4'b0000, 4'b1111, 1, 1, 0);
    cyc(1, 4'b0000, 4'b1111, 0, 0, 1);
    repeat (2) cyc(1, 4'b0000, 4'b1111, 0, 0, 0);

    // Random traffic
    begin
      bit [NSRC-1:0] en;
      en = 4'b1111;
      for (int n = 0; n < 3000; n++) begin
        bit [NSRC-1:0] irq;
        bit            r;
        r   = ($urandom_range(0, 299) != 0);
        irq = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
        if ($urandom_range(0, 19) == 0) en = NSRC'($urandom);
        cyc(r, irq, en,
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 4) == 0));
      end
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued expected 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_controller.md
Name: exc_controller

Overview:
- Exception requester that drives the datapath's exception inputs (Exc, EStatus) and consumes its ExcAck. It is the initiator side of that handshake.
- Latches external interrupt pulses into sticky pending bits and prioritizes them against the synchronous invalid-opcode exception.
- Holds the request until the datapath acknowledges, then blocks nested exceptions until ERet.
- Sits beside the control unit at processor top level.

Parameters:
NSRC, 4, number of external interrupt sources (1..8)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (state clears while reset=0)
ext_irq  input  NSRC  external interrupt request pulses; bit i sets pending[i]
irq_en  input  NSRC  per-source enable; masked sources stay pending but never raise
inv_opcode  input  1  control unit flags the current instruction as illegal (synchronous, level)
ExcAck  input  1  datapath acknowledges the exception this cycle
ERet  input  1  current instruction is ERET
Exc  output  1  exception request to datapath
EStatus  output  4  cause code for the request
pending  output  NSRC  sticky pending interrupt bits
in_handler  output  1  high while the handler runs
double_fault  output  1  sticky: inv_opcode seen while in_handler

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pending=0, Exc=0, EStatus=0, in_handler=0, double_fault=0, taken_src=0.
- Cause encoding and priority:
  - Invalid opcode → 4'b0010.
  - External source i → 4'b1000+i.
  - Priority: inv_opcode first, then the lowest-index enabled pending source.
- Pending update, each edge: pending <= (pending & ~clr_mask) | ext_irq. A set on the same edge as a clear wins, so the bit stays pending.
- States: IDLE, RAISE, HANDLER.
- IDLE:
  - If inv_opcode=1, Exc=1 combinationally in the same cycle, EStatus=0010. The faulting instruction must see Exc in its own cycle.
  - If ExcAck=1 at that edge → HANDLER. If ExcAck=0 → RAISE with sync cause held.
  - Else, if any (pending & irq_en) at the edge: register EStatus=1000+i and taken_src=i, Exc=1 from next cycle → RAISE. Interrupt latency from the ext_irq pulse is 2 cycles to Exc=1: one edge to pend, one edge to raise.
  - ERet in IDLE is ignored.
- RAISE:
  - Exc held at 1 with EStatus stable until ExcAck=1 at an edge.
  - If inv_opcode=1 during RAISE, EStatus shows 0010 combinationally for that cycle. The external cause stays registered and is not cleared if acked in that cycle.
  - On ack edge:
    - If the acked cause was external, clear pending[taken_src].
    - Exc=0 next cycle, in_handler=1 → HANDLER.
  - irq_en dropping for the raised source during RAISE does not withdraw the request.
- HANDLER:
  - Exc=0 regardless of pending or inv_opcode. New ext_irq pulses accumulate in pending.
  - inv_opcode=1 at an edge sets double_fault (sticky until reset); state is unchanged.
  - ERet=1 at an edge → IDLE, in_handler=0. Pending enabled sources may raise starting at that next edge (Exc one cycle after leaving HANDLER).
  - ExcAck in HANDLER or IDLE without Exc is ignored.
- Reset mid-RAISE or mid-HANDLER aborts immediately. All outputs return to reset values; lost pending bits are not recovered.
- EStatus is 0 whenever Exc=0.

Test Plan:
- Reset with reset=0 while ext_irq=4'b0101 → all outputs 0. Release reset, pulse ext_irq[2] one cycle → pending=0100 next cycle, Exc=1/EStatus=1010 one cycle later; hold ExcAck=0 for 3 cycles → Exc stays 1, EStatus=1010.
- Continue: ExcAck=1 one cycle → pending=0000, Exc=0, in_handler=1; ERet=1 → in_handler=0, state IDLE, no Exc.
- Pulse ext_irq=4'b0110 with irq_en=4'b1111 → EStatus=1001 first. After ack+ERet, EStatus=1010 raised next; pending[2] cleared only at its own ack.
- IDLE, inv_opcode=1 with ExcAck=1 same cycle → Exc=1 and EStatus=0010 combinationally that cycle, in_handler=1 next. Assert inv_opcode in HANDLER → double_fault=1, Exc=0; survives ERet; cleared only by reset.
- irq_en=4'b1110, pulse ext_irq[0] → pending=0001, Exc never rises. Set irq_en[0]=1 → Exc=1/EStatus=1000 next edge.
- In RAISE with EStatus=1001, pulse ext_irq[1] on the ack edge → pending[1] stays 1. Assert reset=0 during HANDLER → pending, in_handler, Exc all 0 immediately.
